// File: rtl/fifo_almost_full_if.sv
// Handshake bundle between an upstream writer, the almost-full FIFO and a downstream reader.
interface fifo_almost_full_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  full_n;
  logic                  write_ce;
  logic                  write;
  logic [DATA_WIDTH-1:0] din;
  logic                  empty_n;
  logic                  read_ce;
  logic                  read;
  logic [DATA_WIDTH-1:0] dout;

  modport master (
    input  full_n, empty_n, dout,
    output write_ce, write, din, read_ce, read
  );

  modport slave (
    input  write_ce, write, din, read_ce, read,
    output full_n, empty_n, dout
  );
endinterface

// File: rtl/fifo_almost_full.sv
// First-word fall-through FIFO whose full flag drops GRACE_PERIOD words early,
// giving a pipelined upstream room to land in-flight writes.
module fifo_almost_full #(
  parameter     MEM_STYLE    = "auto",
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int DEPTH        = 32,
  parameter int GRACE_PERIOD = 2
) (
  input  logic                clk,
  input  logic                reset,
  fifo_almost_full_if.slave   fifo_if
);

  localparam int AF_INT   = DEPTH - GRACE_PERIOD;
  localparam int LAST_INT = DEPTH - 1;

  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AF_C     = AF_INT[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = LAST_INT[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  (* ram_style = MEM_STYLE *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  wr_req, rd_req, wr_fire, rd_fire, mem_we;

  always_comb begin
    wr_req   = fifo_if.write & fifo_if.write_ce;
    rd_req   = fifo_if.read & fifo_if.read_ce;
    rd_fire  = rd_req & (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    wr_fire  = wr_req & ((count_q < DEPTH_C) | rd_fire);
    mem_we   = wr_fire & ~reset;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (rd_fire) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    end
    if (wr_fire) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (wr_fire && !rd_fire) begin
      count_d = count_q + CNT_ONE;
    end else if (rd_fire && !wr_fire) begin
      count_d = count_q - CNT_ONE;
    end

    if (reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // Storage is deliberately not reset; the pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= fifo_if.din;
    end
  end

  assign fifo_if.dout    = mem[rd_ptr_q];
  assign fifo_if.empty_n = (count_q != '0);
  assign fifo_if.full_n  = (count_q < AF_C);

endmodule
